// File: rtl/uart_imem_loader.sv
// rtl/uart_imem_loader.sv - UART boot loader that writes a framed program image into instruction memory
//
// Receives 8N1 bytes on rx (oversampled by CLKS_PER_BIT), parses a frame
// {SYNC_BYTE, len_lo, len_hi, payload[4*len]} and writes the payload as
// little-endian 32-bit words to consecutive instruction-memory word addresses
// starting at 0. The core is held in reset (cpu_hold) while a frame is loaded.
//
// Optional build macro: LOADER_CHECKSUM_EN
//   When defined, each frame carries one trailing byte equal to the XOR of all
//   payload bytes; a mismatch sets err and suppresses done.
//
// Ports:
//   clk        in   system clock, posedge
//   rst        in   asynchronous active-high reset
//   rx         in   UART receive line, idles high
//   cpu_hold   out  high while a frame is being loaded
//   imem_we    out  one-cycle instruction-memory write strobe
//   imem_addr  out  [ADDR_W-1:0] word address of the write
//   imem_wdata out  [31:0] word to write
//   done       out  one-cycle pulse when a load completes successfully
//   err        out  sticky error flag, cleared by the next SYNC_BYTE
module uart_imem_loader #(
    parameter int         CLKS_PER_BIT = 868,
    parameter int         ADDR_W       = 14,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    output logic              cpu_hold,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              done,
    output logic              err
);

    localparam int              CNT_W   = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [16:0]      DEPTH   = 17'(1 << ADDR_W);

    // ------------------------------------------------------------------
    // rx synchroniser; rx_prev gives the falling-edge detector its history
    // ------------------------------------------------------------------
    logic rx_meta, rx_sync, rx_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // ------------------------------------------------------------------
    // UART receiver
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

    rx_state_t        r_state, r_next;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit;
    logic [7:0]       r_shift;
    logic             byte_valid;
    logic             frame_err;
    logic [7:0]       byte_data;
    logic             half_tick, full_tick;

    assign half_tick = (r_cnt == HALF_M1);
    assign full_tick = (r_cnt == FULL_M1);

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (rx_prev && !rx_sync) r_next = R_START;
            // A start bit that is high again at mid-bit was a glitch.
            R_START: if (half_tick) r_next = rx_sync ? R_IDLE : R_DATA;
            R_DATA:  if (full_tick && r_bit == 3'd7) r_next = R_STOP;
            R_STOP:  if (full_tick) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= R_IDLE;
            r_cnt      <= '0;
            r_bit      <= '0;
            r_shift    <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            byte_data  <= '0;
        end else begin
            r_state    <= r_next;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            // The counter restarts at mid start bit so every later sample
            // lands in the middle of its bit.
            if (r_state == R_IDLE || (r_state == R_START && half_tick) || full_tick)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + 1'b1;
            if (r_state == R_START)
                r_bit <= '0;
            if (r_state == R_DATA && full_tick) begin
                r_shift <= {rx_sync, r_shift[7:1]};
                r_bit   <= r_bit + 3'd1;
            end
            if (r_state == R_STOP && full_tick) begin
                if (rx_sync) begin
                    byte_valid <= 1'b1;
                    byte_data  <= r_shift;
                end else begin
                    frame_err <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame loader
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        WRITE,
`ifdef LOADER_CHECKSUM_EN
        CHECK,
`endif
        DONE
    } ld_state_t;

`ifdef LOADER_CHECKSUM_EN
    localparam ld_state_t END_STATE = CHECK;
    logic [7:0] csum;
`else
    localparam ld_state_t END_STATE = DONE;
`endif

    ld_state_t   l_state, l_next;
    logic [7:0]  len_lo;
    logic [15:0] len;
    logic [1:0]  byte_k;
    logic [16:0] word_cnt;
    logic [15:0] hdr_len;
    logic        is_sync;
    logic        len_too_big;
    logic        last_word;

    assign hdr_len     = {byte_data, len_lo};
    assign is_sync     = byte_valid && (byte_data == SYNC_BYTE);
    assign len_too_big = ({1'b0, hdr_len} > DEPTH);
    assign last_word   = ((word_cnt + 17'd1) == {1'b0, len});

    always_comb begin
        l_next = l_state;
        case (l_state)
            IDLE:   if (is_sync) l_next = LEN_LO;
            LEN_LO: if (byte_valid) l_next = LEN_HI;
            LEN_HI: begin
                if (byte_valid) begin
                    if (hdr_len == 16'd0)
                        l_next = END_STATE;
                    else if (len_too_big)
                        l_next = IDLE;
                    else
                        l_next = DATA;
                end
            end
            DATA:   if (byte_valid && byte_k == 2'd3) l_next = WRITE;
            WRITE:  l_next = last_word ? END_STATE : DATA;
`ifdef LOADER_CHECKSUM_EN
            CHECK:  if (byte_valid) l_next = (byte_data == csum) ? DONE : IDLE;
`endif
            DONE:   l_next = IDLE;
            default: l_next = IDLE;
        endcase
        // A broken byte aborts the frame; whatever was written stays written.
        if (frame_err && l_state != IDLE)
            l_next = IDLE;
    end

    assign cpu_hold = (l_state != IDLE) && (l_state != DONE);
    assign imem_we  = (l_state == WRITE);
    assign done     = (l_state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            l_state    <= IDLE;
            imem_addr  <= '0;
            imem_wdata <= '0;
            err        <= 1'b0;
            len_lo     <= '0;
            len        <= '0;
            byte_k     <= '0;
            word_cnt   <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum       <= '0;
`endif
        end else begin
            l_state <= l_next;
            if (frame_err)
                err <= 1'b1;
            case (l_state)
                IDLE: begin
                    if (is_sync) begin
                        err       <= 1'b0;
                        imem_addr <= '0;
                        byte_k    <= '0;
                        word_cnt  <= '0;
`ifdef LOADER_CHECKSUM_EN
                        csum      <= '0;
`endif
                    end
                end
                LEN_LO: if (byte_valid) len_lo <= byte_data;
                LEN_HI: begin
                    if (byte_valid) begin
                        len <= hdr_len;
                        if (len_too_big)
                            err <= 1'b1;
                    end
                end
                DATA: begin
                    if (byte_valid) begin
                        imem_wdata[{byte_k, 3'b000} +: 8] <= byte_data;
                        byte_k <= byte_k + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                        csum   <= csum ^ byte_data;
`endif
                    end
                end
                WRITE: begin
                    // Wraps to 0 after a full-depth image.
                    imem_addr <= imem_addr + 1'b1;
                    word_cnt  <= word_cnt + 17'd1;
                end
`ifdef LOADER_CHECKSUM_EN
                CHECK: if (byte_valid && byte_data != csum) err <= 1'b1;
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_imem_loader.sv
// tb/tb_uart_imem_loader.sv - self-checking bench for uart_imem_loader
module tb_uart_imem_loader;

    localparam int CPB   = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx  = 1'b1;
    logic          cpu_hold, imem_we, done, err;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]    frame_q[$];
    logic [31:0]   word_q[$];
    logic [7:0]    frame_csum;
    logic [AW-1:0] exp_addr[$];
    logic [31:0]   exp_data[$];
    int            exp_done;
    logic          exp_err;

    logic [AW-1:0] got_addr[$];
    logic [31:0]   got_data[$];
    int            done_cnt = 0;
    int            hold_bad = 0;

    always #5 clk = ~clk;

    uart_imem_loader #(
        .CLKS_PER_BIT(CPB),
        .ADDR_W      (AW),
        .SYNC_BYTE   (8'hA5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .cpu_hold  (cpu_hold),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_wdata(imem_wdata),
        .done      (done),
        .err       (err)
    );

    // Records every write and done pulse; writes must happen under cpu_hold,
    // and done must coincide with cpu_hold already released.
    always @(negedge clk) begin
        if (imem_we) begin
            got_addr.push_back(imem_addr);
            got_data.push_back(imem_wdata);
            if (!cpu_hold) hold_bad++;
        end
        if (done) begin
            done_cnt++;
            if (cpu_hold) hold_bad++;
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic send_frame();
        foreach (frame_q[i]) send_byte(frame_q[i]);
        repeat (4) @(negedge clk);
    endtask

    // Frame = sync, length LE, payload words LE, checksum when enabled.
    task automatic build_frame(input int len);
        logic [7:0] x;
        logic [7:0] b;
        x = 8'h00;
        frame_q.delete();
        frame_q.push_back(8'hA5);
        frame_q.push_back(len[7:0]);
        frame_q.push_back(len[15:8]);
        for (int w = 0; w < len; w++) begin
            for (int k = 0; k < 4; k++) begin
                b = word_q[w][8*k +: 8];
                frame_q.push_back(b);
                x = x ^ b;
            end
        end
        frame_csum = x;
`ifdef LOADER_CHECKSUM_EN
        frame_q.push_back(x);
`endif
    endtask

    // Expected effect of the frame in frame_q, derived from its bytes.
    task automatic model_frame();
        int          len;
        logic [7:0]  x;
        logic [31:0] word;
        exp_addr.delete();
        exp_data.delete();
        exp_done = 0;
        exp_err  = 1'b0;
        x        = 8'h00;
        len      = int'({frame_q[2], frame_q[1]});
        if (len > DEPTH) begin
            exp_err = 1'b1;
            return;
        end
        for (int w = 0; w < len; w++) begin
            word = 32'h0;
            for (int k = 0; k < 4; k++) begin
                word[8*k +: 8] = frame_q[3 + 4*w + k];
                x = x ^ frame_q[3 + 4*w + k];
            end
            exp_addr.push_back(AW'(w % DEPTH));
            exp_data.push_back(word);
        end
`ifdef LOADER_CHECKSUM_EN
        if (x != frame_q[3 + 4*len]) begin
            exp_err = 1'b1;
            return;
        end
`endif
        exp_done = 1;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++; if (cpu_hold !== 1'b0) begin n_fail++; $display("FAIL reset cpu_hold: got %b expected 0", cpu_hold); end
        n_checks++; if (imem_we !== 1'b0) begin n_fail++; $display("FAIL reset imem_we: got %b expected 0", imem_we); end
        n_checks++; if (imem_addr !== '0) begin n_fail++; $display("FAIL reset imem_addr: got %h expected 0", imem_addr); end
        n_checks++; if (imem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset imem_wdata: got %h expected 0", imem_wdata); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset done: got %b expected 0", done); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset err: got %b expected 0", err); end
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_two_word();
        int w0, d0, h0;
        w0 = got_addr.size(); d0 = done_cnt; h0 = hold_bad;
        word_q = '{32'h0000_0013, 32'h0010_0093};
        build_frame(2);
        model_frame();
        send_byte(frame_q[0]);
        n_checks++; if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL two_word hold_after_sync: got %b expected 1", cpu_hold); end
        for (int i = 1; i < frame_q.size(); i++) send_byte(frame_q[i]);
        repeat (4) @(negedge clk);
        n_checks++;
        if (got_addr.size() - w0 !== exp_addr.size()) begin
            n_fail++; $display("FAIL two_word write_count: got %0d expected %0d", got_addr.size() - w0, exp_addr.size());
        end else begin
            for (int i = 0; i < exp_addr.size(); i++) begin
                n_checks++;
                if (got_addr[w0+i] !== exp_addr[i] || got_data[w0+i] !== exp_data[i]) begin
                    n_fail++; $display("FAIL two_word write%0d: got %0d/%h expected %0d/%h", i, got_addr[w0+i], got_data[w0+i], exp_addr[i], exp_data[i]);
                end
            end
        end
        n_checks++; if (done_cnt - d0 !== exp_done) begin n_fail++; $display("FAIL two_word done_count: got %0d expected %0d", done_cnt - d0, exp_done); end
        n_checks++; if (err !== exp_err) begin n_fail++; $display("FAIL two_word err: got %b expected %b", err, exp_err); end
        n_checks++; if (hold_bad - h0 !== 0) begin n_fail++; $display("FAIL two_word hold_window: got %0d violations expected 0", hold_bad - h0); end
        n_checks++; if (cpu_hold !== 1'b0) begin n_fail++; $display("FAIL two_word hold_end: got %b expected 0", cpu_hold); end
    endtask

    task automatic test_noise();
        int w0, d0;
        w0 = got_addr.size(); d0 = done_cnt;
        send_byte(8'h55);
        @(negedge clk);
        rx = 1'b0;
        repeat (2) @(negedge clk);
        rx = 1'b1;
        repeat (30) @(negedge clk);
        n_checks++; if (cpu_hold !== 1'b0) begin n_fail++; $display("FAIL noise cpu_hold: got %b expected 0", cpu_hold); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL noise err: got %b expected 0", err); end
        n_checks++; if (got_addr.size() !== w0) begin n_fail++; $display("FAIL noise writes: got %0d expected 0", got_addr.size() - w0); end
        // The receiver must still frame a real byte correctly after the glitch.
        word_q.delete();
        build_frame(0);
        send_frame();
        n_checks++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL noise recover_done: got %0d expected 1", done_cnt - d0); end
    endtask

    task automatic test_framing_err();
        int w0, d0;
        w0 = got_addr.size(); d0 = done_cnt;
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'hAA);
        n_checks++; if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL framing hold_before: got %b expected 1", cpu_hold); end
        send_byte(8'h3C, 1'b0);
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL framing err_set: got %b expected 1", err); end
        n_checks++; if (cpu_hold !== 1'b0) begin n_fail++; $display("FAIL framing hold_drop: got %b expected 0", cpu_hold); end
        n_checks++; if (got_addr.size() !== w0) begin n_fail++; $display("FAIL framing writes: got %0d expected 0", got_addr.size() - w0); end
        send_byte(8'hA5);
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL framing err_clear: got %b expected 0", err); end
        word_q.delete();
        build_frame(0);
        for (int i = 1; i < frame_q.size(); i++) send_byte(frame_q[i]);
        repeat (4) @(negedge clk);
        n_checks++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL framing done_after: got %0d expected 1", done_cnt - d0); end
    endtask

    task automatic test_length_bounds();
        int w0, d0;
        w0 = got_addr.size(); d0 = done_cnt;
        word_q.delete();
        build_frame(0);
        model_frame();
        send_frame();
        n_checks++; if (done_cnt - d0 !== exp_done) begin n_fail++; $display("FAIL len0 done: got %0d expected %0d", done_cnt - d0, exp_done); end
        n_checks++; if (got_addr.size() - w0 !== 0) begin n_fail++; $display("FAIL len0 writes: got %0d expected 0", got_addr.size() - w0); end
        w0 = got_addr.size(); d0 = done_cnt;
        frame_q = '{8'hA5, 8'h11, 8'h00};
        model_frame();
        send_frame();
        n_checks++; if (err !== exp_err) begin n_fail++; $display("FAIL len17 err: got %b expected %b", err, exp_err); end
        n_checks++; if (cpu_hold !== 1'b0) begin n_fail++; $display("FAIL len17 cpu_hold: got %b expected 0", cpu_hold); end
        n_checks++; if (got_addr.size() - w0 !== 0) begin n_fail++; $display("FAIL len17 writes: got %0d expected 0", got_addr.size() - w0); end
        n_checks++; if (done_cnt - d0 !== 0) begin n_fail++; $display("FAIL len17 done: got %0d expected 0", done_cnt - d0); end
    endtask

    task automatic test_random_frames();
        int w0, d0, len;
        for (int f = 0; f < 3; f++) begin
            len = (f == 1) ? DEPTH : int'($urandom_range(1, DEPTH - 1));
            word_q.delete();
            for (int w = 0; w < len; w++) word_q.push_back($urandom);
            build_frame(len);
            model_frame();
            w0 = got_addr.size(); d0 = done_cnt;
            send_frame();
            n_checks++;
            if (got_addr.size() - w0 !== exp_addr.size()) begin
                n_fail++; $display("FAIL random%0d write_count: got %0d expected %0d", f, got_addr.size() - w0, exp_addr.size());
            end else begin
                for (int i = 0; i < exp_addr.size(); i++) begin
                    n_checks++;
                    if (got_addr[w0+i] !== exp_addr[i] || got_data[w0+i] !== exp_data[i]) begin
                        n_fail++; $display("FAIL random%0d write%0d: got %0d/%h expected %0d/%h", f, i, got_addr[w0+i], got_data[w0+i], exp_addr[i], exp_data[i]);
                    end
                end
            end
            n_checks++; if (done_cnt - d0 !== exp_done) begin n_fail++; $display("FAIL random%0d done: got %0d expected %0d", f, done_cnt - d0, exp_done); end
            n_checks++; if (err !== exp_err) begin n_fail++; $display("FAIL random%0d err: got %b expected %b", f, err, exp_err); end
            if (len == DEPTH) begin
                n_checks++; if (imem_addr !== '0) begin n_fail++; $display("FAIL random%0d addr_wrap: got %0d expected 0", f, imem_addr); end
            end
        end
    endtask

    task automatic test_reset_midload();
        int w0, d0, len;
        len = int'($urandom_range(2, 5));
        word_q.delete();
        for (int w = 0; w < len; w++) word_q.push_back($urandom | 32'h0000_0101);
        build_frame(len);
        for (int i = 0; i < 5; i++) send_byte(frame_q[i]);
        n_checks++; if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL midreset hold_before: got %b expected 1", cpu_hold); end
        #2 rst = 1'b1;
        #1;
        n_checks++; if (cpu_hold !== 1'b0) begin n_fail++; $display("FAIL midreset cpu_hold: got %b expected 0", cpu_hold); end
        n_checks++; if (imem_we !== 1'b0) begin n_fail++; $display("FAIL midreset imem_we: got %b expected 0", imem_we); end
        n_checks++; if (imem_addr !== '0) begin n_fail++; $display("FAIL midreset imem_addr: got %0d expected 0", imem_addr); end
        n_checks++; if (imem_wdata !== 32'h0) begin n_fail++; $display("FAIL midreset imem_wdata: got %h expected 0", imem_wdata); end
        n_checks++; if (done !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL midreset done_err: got %b/%b expected 0/0", done, err); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        model_frame();
        w0 = got_addr.size(); d0 = done_cnt;
        send_frame();
        n_checks++;
        if (got_addr.size() - w0 !== exp_addr.size()) begin
            n_fail++; $display("FAIL midreset write_count: got %0d expected %0d", got_addr.size() - w0, exp_addr.size());
        end else begin
            for (int i = 0; i < exp_addr.size(); i++) begin
                n_checks++;
                if (got_addr[w0+i] !== exp_addr[i] || got_data[w0+i] !== exp_data[i]) begin
                    n_fail++; $display("FAIL midreset write%0d: got %0d/%h expected %0d/%h", i, got_addr[w0+i], got_data[w0+i], exp_addr[i], exp_data[i]);
                end
            end
        end
        n_checks++; if (done_cnt - d0 !== exp_done) begin n_fail++; $display("FAIL midreset done: got %0d expected %0d", done_cnt - d0, exp_done); end
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum();
        int w0, d0;
        word_q = '{32'h0000_0013, 32'h0010_0093};
        build_frame(2);
        frame_q[frame_q.size() - 1] = 8'h91;
        model_frame();
        w0 = got_addr.size(); d0 = done_cnt;
        send_frame();
        n_checks++; if (err !== exp_err) begin n_fail++; $display("FAIL checksum err: got %b expected %b", err, exp_err); end
        n_checks++; if (done_cnt - d0 !== exp_done) begin n_fail++; $display("FAIL checksum done: got %0d expected %0d", done_cnt - d0, exp_done); end
        n_checks++; if (cpu_hold !== 1'b0) begin n_fail++; $display("FAIL checksum cpu_hold: got %b expected 0", cpu_hold); end
        n_checks++; if (got_addr.size() - w0 !== exp_addr.size()) begin n_fail++; $display("FAIL checksum writes: got %0d expected %0d", got_addr.size() - w0, exp_addr.size()); end
    endtask
`endif

    initial begin
        test_reset();
        test_two_word();
        test_noise();
        test_framing_err();
        test_length_bounds();
        test_random_frames();
        test_reset_midload();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
